// File: rtl/dram_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : dram_pkg
// Brief  : Shared derivations and types for the sampler-to-DRAM packer.
// Rev    : 1.0  initial parametrised release
// ---------------------------------------------------------------------------
package dram_pkg;

  // Which condition caused a completed word to be handed to the queue.
  typedef enum logic [1:0] {
    PUSH_NONE  = 2'd0,
    PUSH_FULL  = 2'd1,
    PUSH_FLUSH = 2'd2
  } push_src_e;

  // Ceiling log2, usable in constant expressions; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    while ((64'd1 << res) < 64'(value)) begin
      res = res + 1;
    end
    return res;
  endfunction

  // Number of samples held in one memory word.
  function automatic int unsigned calc_pack(input int unsigned mem_w,
                                            input int unsigned sample_w);
    return mem_w / sample_w;
  endfunction

  // Address units covered by one memory word.
  function automatic int unsigned calc_adx_step(input int unsigned mem_w,
                                                input int unsigned word_bytes);
    return mem_w / (8 * word_bytes);
  endfunction

  // True when a memory word holds a whole number (at least one) of samples.
  function automatic bit width_ok(input int unsigned mem_w,
                                  input int unsigned sample_w);
    return (sample_w != 0) && (mem_w >= sample_w) && ((mem_w % sample_w) == 0);
  endfunction

  // True when depth is a power of two and at least 2.
  function automatic bit depth_ok(input int unsigned depth);
    return (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/packer_word_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : packer_word_fifo
// Brief  : Synchronous FIFO holding completed {data, address} words. Head is
//          presented combinationally; a push while full is accepted only if
//          a pop happens in the same cycle.
// Rev    : 1.0  initial parametrised release
// ---------------------------------------------------------------------------
module packer_word_fifo
  import dram_pkg::*;
#(
  parameter int unsigned WIDTH = 155,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [WIDTH-1:0]       data_i,
  output logic [WIDTH-1:0]       head_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [clog2(DEPTH):0]  level_o
);

  localparam int unsigned PTR_W = clog2(DEPTH);
  localparam int unsigned LVL_W = clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [LVL_W-1:0] level_q;
  logic             w_do_push;
  logic             w_do_pop;

  assign full_o  = (level_q == LVL_W'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign head_o  = mem_q[rd_ptr_q];

  // Pops only from a non-empty queue; a push into a full queue needs a
  // simultaneous pop to make room, otherwise the word is refused.
  always_comb begin
    w_do_pop  = pop_i & ~empty_o;
    w_do_push = push_i & (~full_o | w_do_pop);
  end

  // Storage array; contents need no reset because the head is masked when empty.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (w_do_push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (w_do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/dram_packer_q.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : dram_packer_q
// Brief  : Packs sampler samples into memory-width words, tags each word
//          with an address from a circular region, and queues the words for
//          the DDR write port. Supports partial-word flush and sticky
//          overflow reporting.
// Rev    : 1.0  initial parametrised release
// ---------------------------------------------------------------------------
module dram_packer_q
  import dram_pkg::*;
#(
  parameter int unsigned SAMPLE_W   = 32,
  parameter int unsigned MEM_W      = 128,
  parameter int unsigned ADX_W      = 27,
  parameter int unsigned WORD_BYTES = 2,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   we,
  input  logic [SAMPLE_W-1:0]    write_data,
  input  logic                   flush,
  input  logic                   adx_load,
  input  logic [ADX_W-1:0]       base_adx,
  input  logic [ADX_W-1:0]       end_adx,
  output logic [MEM_W-1:0]       dram_data,
  output logic [ADX_W-1:0]       dram_adx,
  output logic                   write_req,
  input  logic                   write_allowed,
  output logic [clog2(DEPTH):0]  q_level,
  output logic                   overflow,
  output logic                   busy
);

  localparam int unsigned PACK     = calc_pack(MEM_W, SAMPLE_W);
  localparam int unsigned ADX_STEP = calc_adx_step(MEM_W, WORD_BYTES);
  localparam int unsigned LANE_W   = (PACK > 1) ? clog2(PACK) : 1;
  localparam int unsigned ENTRY_W  = MEM_W + ADX_W;

  // Reject configurations the packing and queue logic cannot represent.
  generate
    if (!width_ok(MEM_W, SAMPLE_W)) begin : g_bad_width
      $fatal(1, "dram_packer_q: MEM_W must be a non-zero multiple of SAMPLE_W");
    end
    if (!depth_ok(DEPTH)) begin : g_bad_depth
      $fatal(1, "dram_packer_q: DEPTH must be a power of two and at least 2");
    end
  endgenerate

  logic [LANE_W-1:0]     lane_q, lane_d;
  logic [MEM_W-1:0]      buf_q, buf_d;
  logic [ADX_W-1:0]      adx_q, adx_d;
  logic                  ovf_q, ovf_d;

  logic [MEM_W-1:0]      w_ins;
  logic [ADX_W-1:0]      w_adx_inc;
  push_src_e             w_push_src;
  logic                  w_push;
  logic                  w_pop;
  logic [ENTRY_W-1:0]    w_head;
  logic                  w_full;
  logic                  w_empty;
  logic [clog2(DEPTH):0] w_level;

  // Assembly buffer with the incoming sample dropped into its lane; the
  // pushed word is taken from here so a flush together with we keeps the sample.
  always_comb begin
    w_ins = buf_q;
    for (int k = 0; k < PACK; k++) begin
      if (we && (lane_q == LANE_W'(k))) begin
        w_ins[k*SAMPLE_W +: SAMPLE_W] = write_data;
      end
    end
  end

  // Decide whether a word leaves the buffer this cycle; adx_load suppresses
  // any push because the partial word is being discarded.
  always_comb begin
    w_push_src = PUSH_NONE;
    if (!adx_load) begin
      if (we && (lane_q == LANE_W'(PACK - 1))) begin
        w_push_src = PUSH_FULL;
      end else if (flush && (we || (lane_q != '0))) begin
        w_push_src = PUSH_FLUSH;
      end
    end
    w_push = (w_push_src != PUSH_NONE);
  end

  // Next-state for lane, buffer, address counter and sticky overflow. The
  // counter steps on every push, dropped or not, so addresses stay aligned
  // with the sample stream.
  always_comb begin
    w_adx_inc = adx_q + ADX_W'(ADX_STEP);
    lane_d    = lane_q;
    buf_d     = buf_q;
    adx_d     = adx_q;
    if (adx_load) begin
      lane_d = '0;
      buf_d  = '0;
      adx_d  = base_adx;
    end else if (w_push) begin
      lane_d = '0;
      buf_d  = '0;
      adx_d  = (w_adx_inc == end_adx) ? base_adx : w_adx_inc;
    end else if (we) begin
      lane_d = lane_q + 1'b1;
      buf_d  = w_ins;
    end
    ovf_d = ovf_q | (w_push & w_full & ~w_pop);
  end

  // Packer state registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      lane_q <= '0;
      buf_q  <= '0;
      adx_q  <= base_adx;
      ovf_q  <= 1'b0;
    end else begin
      lane_q <= lane_d;
      buf_q  <= buf_d;
      adx_q  <= adx_d;
      ovf_q  <= ovf_d;
    end
  end

  packer_word_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .push_i  (w_push),
    .pop_i   (w_pop),
    .data_i  ({w_ins, adx_q}),
    .head_o  (w_head),
    .full_o  (w_full),
    .empty_o (w_empty),
    .level_o (w_level)
  );

  // Memory-side handshake and head presentation, masked while empty.
  always_comb begin
    write_req = ~w_empty & write_allowed;
    w_pop     = write_req;
    dram_data = w_empty ? '0 : w_head[ADX_W +: MEM_W];
    dram_adx  = w_empty ? '0 : w_head[ADX_W-1:0];
    q_level   = w_level;
    overflow  = ovf_q;
    busy      = (lane_q != '0) | ~w_empty;
  end

endmodule
`default_nettype wire

// File: tb/tb_dram_packer_q.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : tb_dram_packer_q
// Brief  : Scoreboard bench for dram_packer_q (default parameters).
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
module tb_dram_packer_q;

  logic         clk;
  logic         resetn;
  logic         we;
  logic [31:0]  write_data;
  logic         flush;
  logic         adx_load;
  logic [26:0]  base_adx;
  logic [26:0]  end_adx;
  logic [127:0] dram_data;
  logic [26:0]  dram_adx;
  logic         write_req;
  logic         write_allowed;
  logic [2:0]   q_level;
  logic         overflow;
  logic         busy;

  int total = 0;
  int bad   = 0;
  int n_pops = 0;

  logic [154:0] exp_q[$];
  logic [26:0]  seen_adx[$];

  // Reference model state
  int           m_lane;
  logic [127:0] m_buf;
  logic [26:0]  m_adx;

  dram_packer_q dut (
    .clk           (clk),
    .resetn        (resetn),
    .we            (we),
    .write_data    (write_data),
    .flush         (flush),
    .adx_load      (adx_load),
    .base_adx      (base_adx),
    .end_adx       (end_adx),
    .dram_data     (dram_data),
    .dram_adx      (dram_adx),
    .write_req     (write_req),
    .write_allowed (write_allowed),
    .q_level       (q_level),
    .overflow      (overflow),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: every write strobe pops one expected word.
  always @(negedge clk) begin
    if (resetn && write_req) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write: got data=%h adx=%0d, required no write", dram_data, dram_adx);
      end else begin
        logic [154:0] e;
        e = exp_q.pop_front();
        n_pops++;
        seen_adx.push_back(dram_adx);
        if (dram_data !== e[154:27] || dram_adx !== e[26:0]) begin
          bad++;
          $display("FAIL word_out: got data=%h adx=%0d, required data=%h adx=%0d",
                   dram_data, dram_adx, e[154:27], e[26:0]);
        end
      end
    end
  end

  // Drive one cycle of stimulus and advance the model alongside it.
  task automatic step(input logic i_we, input logic [31:0] d, input logic i_fl, input logic i_ld);
    logic do_push;
    logic pop_now;
    we = i_we; write_data = d; flush = i_fl; adx_load = i_ld;
    if (i_ld) begin
      m_adx = base_adx; m_lane = 0; m_buf = '0;
    end else begin
      do_push = 1'b0;
      if (i_we) begin
        m_buf[m_lane*32 +: 32] = d;
        if (m_lane == 3) do_push = 1'b1;
        else m_lane++;
      end
      if (i_fl && (m_lane != 0 || i_we)) do_push = 1'b1;
      if (do_push) begin
        pop_now = (exp_q.size() > 0) && write_allowed;
        if (exp_q.size() < 4 || pop_now) exp_q.push_back({m_buf, m_adx});
        m_adx = m_adx + 27'd8;
        if (m_adx == end_adx) m_adx = base_adx;
        m_buf = '0;
        m_lane = 0;
      end
    end
    @(posedge clk); #1;
    we = 1'b0; flush = 1'b0; adx_load = 1'b0;
  endtask

  task automatic do_reset();
    resetn = 1'b0; we = 1'b0; flush = 1'b0; adx_load = 1'b0; write_data = '0;
    @(posedge clk); #1;
    resetn = 1'b1;
    exp_q.delete();
    m_lane = 0; m_buf = '0; m_adx = base_adx;
  endtask

  task automatic drain();
    write_allowed = 1'b1;
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) step(1'b0, 32'd0, 1'b0, 1'b0);
    step(1'b0, 32'd0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    base_adx = 27'd0; end_adx = 27'd64; write_allowed = 1'b1;
    do_reset();
    total++; if (write_req !== 1'b0) begin bad++; $display("FAIL reset_write_req: got %b, required 0", write_req); end
    total++; if (q_level !== 3'd0) begin bad++; $display("FAIL reset_q_level: got %0d, required 0", q_level); end
    total++; if (busy !== 1'b0 || overflow !== 1'b0) begin bad++; $display("FAIL reset_flags: got busy=%b ovf=%b, required 0 0", busy, overflow); end
    total++; if (dram_data !== 128'd0 || dram_adx !== 27'd0) begin bad++; $display("FAIL reset_head: got %h @%0d, required 0 @0", dram_data, dram_adx); end
  endtask

  task automatic test_basic();
    int p0;
    p0 = n_pops;
    seen_adx.delete();
    for (int i = 1; i <= 8; i++) step(1'b1, 32'(i), 1'b0, 1'b0);
    drain();
    total++; if (n_pops - p0 !== 2) begin bad++; $display("FAIL basic_pops: got %0d, required 2", n_pops - p0); end
    total++; if (seen_adx.size() != 2 || seen_adx[0] !== 27'd0 || seen_adx[1] !== 27'd8) begin
      bad++; $display("FAIL basic_adx: got count %0d, required adx 0,8", seen_adx.size()); end
    total++; if (q_level !== 3'd0 || exp_q.size() != 0) begin bad++; $display("FAIL basic_drain: got level=%0d left=%0d, required 0 0", q_level, exp_q.size()); end
  endtask

  task automatic test_flush();
    logic [127:0] want;
    want = 128'h00000000_00000000_0000000B_0000000A;
    do_reset();
    write_allowed = 1'b0;
    step(1'b1, 32'hA, 1'b0, 1'b0);
    step(1'b1, 32'hB, 1'b0, 1'b0);
    total++; if (busy !== 1'b1 || q_level !== 3'd0) begin bad++; $display("FAIL partial_busy: got busy=%b level=%0d, required 1 0", busy, q_level); end
    step(1'b0, 32'd0, 1'b1, 1'b0);
    total++; if (q_level !== 3'd1) begin bad++; $display("FAIL flush_level: got %0d, required 1", q_level); end
    total++; if (dram_data !== want || dram_adx !== 27'd0) begin bad++; $display("FAIL flush_word: got %h @%0d, required %h @0", dram_data, dram_adx, want); end
    step(1'b0, 32'd0, 1'b1, 1'b0);
    total++; if (q_level !== 3'd1) begin bad++; $display("FAIL flush_noop: got level %0d, required 1", q_level); end
    drain();
    total++; if (busy !== 1'b0 || exp_q.size() != 0) begin bad++; $display("FAIL flush_drain: got busy=%b left=%0d, required 0 0", busy, exp_q.size()); end
  endtask

  task automatic test_overflow();
    base_adx = 27'd0; end_adx = 27'd64;
    do_reset();
    write_allowed = 1'b0;
    for (int i = 0; i < 20; i++) step(1'b1, 32'(100 + i), 1'b0, 1'b0);
    total++; if (q_level !== 3'd4) begin bad++; $display("FAIL ovf_level: got %0d, required 4", q_level); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_set: got %b, required 1", overflow); end
    seen_adx.delete();
    drain();
    total++; if (seen_adx.size() != 4 || seen_adx[0] !== 27'd0 || seen_adx[3] !== 27'd24) begin
      bad++; $display("FAIL ovf_drain_adx: got count %0d, required 4 words adx 0..24", seen_adx.size()); end
    write_allowed = 1'b0;
    for (int i = 0; i < 4; i++) step(1'b1, 32'(200 + i), 1'b0, 1'b0);
    total++; if (dram_adx !== 27'd40 || q_level !== 3'd1) begin bad++; $display("FAIL ovf_next_adx: got adx=%0d level=%0d, required 40 1", dram_adx, q_level); end
    drain();
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky: got %b, required 1", overflow); end
  endtask

  task automatic test_wrap();
    base_adx = 27'd16; end_adx = 27'd32;
    write_allowed = 1'b1;
    step(1'b0, 32'd0, 1'b0, 1'b1);
    seen_adx.delete();
    for (int i = 0; i < 12; i++) step(1'b1, 32'(300 + i), 1'b0, 1'b0);
    drain();
    total++; if (seen_adx.size() != 3 || seen_adx[0] !== 27'd16 || seen_adx[1] !== 27'd24 || seen_adx[2] !== 27'd16) begin
      bad++; $display("FAIL wrap_adx: got count %0d, required adx 16,24,16", seen_adx.size()); end
  endtask

  task automatic test_back_to_back();
    base_adx = 27'd0; end_adx = 27'd64;
    do_reset();
    write_allowed = 1'b0;
    for (int i = 0; i < 19; i++) step(1'b1, 32'(400 + i), 1'b0, 1'b0);
    total++; if (q_level !== 3'd4) begin bad++; $display("FAIL b2b_full: got %0d, required 4", q_level); end
    write_allowed = 1'b1;
    step(1'b1, 32'd419, 1'b0, 1'b0);
    total++; if (q_level !== 3'd4 || overflow !== 1'b0) begin bad++; $display("FAIL b2b_push_pop: got level=%0d ovf=%b, required 4 0", q_level, overflow); end
    drain();
    total++; if (exp_q.size() != 0 || q_level !== 3'd0) begin bad++; $display("FAIL b2b_drain: got left=%0d level=%0d, required 0 0", exp_q.size(), q_level); end
  endtask

  task automatic test_adx_load_reset();
    base_adx = 27'd0; end_adx = 27'd64;
    do_reset();
    write_allowed = 1'b0;
    for (int i = 0; i < 6; i++) step(1'b1, 32'(500 + i), 1'b0, 1'b0);
    step(1'b0, 32'd0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 32'(16 + i), 1'b0, 1'b0);
    total++; if (q_level !== 3'd2) begin bad++; $display("FAIL load_level: got %0d, required 2", q_level); end
    seen_adx.delete();
    drain();
    total++; if (seen_adx.size() != 2 || seen_adx[0] !== 27'd0 || seen_adx[1] !== 27'd0) begin
      bad++; $display("FAIL load_adx: got count %0d, required adx 0,0", seen_adx.size()); end
    write_allowed = 1'b0;
    for (int i = 0; i < 9; i++) step(1'b1, 32'(600 + i), 1'b0, 1'b0);
    write_allowed = 1'b1;
    do_reset();
    total++; if (write_req !== 1'b0 || q_level !== 3'd0 || busy !== 1'b0) begin
      bad++; $display("FAIL midburst_reset: got req=%b level=%0d busy=%b, required 0 0 0", write_req, q_level, busy); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0; we = 1'b0; write_data = '0; flush = 1'b0; adx_load = 1'b0;
    base_adx = '0; end_adx = 27'd64; write_allowed = 1'b0;
    m_lane = 0; m_buf = '0; m_adx = '0;
    @(posedge clk); #1;
    test_reset();
    test_basic();
    test_flush();
    test_overflow();
    test_wrap();
    test_back_to_back();
    test_adx_load_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
